gcd_job_queue: RTL and testbench

- Upstream feeder for the gcd_ci multi-cycle GCD custom-instruction core.
- Buffers operand pairs from a producer (valid/ready) in a FIFO and issues them one at a time to the core using its start/done handshake.
- Returns each result with a sequence tag on a valid/ready output stream.
- Lets software or a DMA engine stream GCD jobs without polling the core.

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_job_fifo.sv | 42 ++++
 rtl/gcd_job_queue.sv | 119 +++++++++++
 tb/tb_gcd_job_queue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the GCD job queue
package gcd_pkg;
  localparam int GCD_W = 32;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, OUT} gcd_state_e;
  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
  } gcd_job_t;
  function automatic logic [GCD_W-1:0] zero_bypass(gcd_job_t j);
    return j.a == '0 ? j.b : j.a;
  endfunction
endpackage

// File: rtl/gcd_job_fifo.sv
// gcd_job_fifo: synchronous FIFO of operand pairs with full/empty flags
module gcd_job_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  gcd_job_t wdata,
  output gcd_job_t rdata,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  gcd_job_t mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // pointers and occupancy; a push while full is refused even if a pop happens
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/gcd_job_queue.sv
// gcd_job_queue: buffers GCD jobs and issues them one at a time to gcd_ci
module gcd_job_queue
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             core_start,
  output logic [31:0]      core_dataa,
  output logic [31:0]      core_datab,
  input  logic             core_done,
  input  logic [31:0]      core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  gcd_state_e state_q, state_d;
  logic start_q, start_d, seen_q, seen_d, valid_q, valid_d, pop, full, empty;
  logic [GCD_W-1:0] dataa_q, dataa_d, datab_q, datab_d, result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d, tcnt_q, tcnt_d;
  gcd_job_t in_job, head;
  assign in_job = '{a: in_a, b: in_b};
  gcd_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid),
    .pop(pop),
    .wdata(in_job),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign in_ready = !full;
  assign core_start = start_q;
  assign core_dataa = dataa_q;
  assign core_datab = datab_q;
  assign out_valid = valid_q;
  assign out_result = result_q;
  assign out_tag = tag_q;
  assign busy = !empty || state_q != IDLE || valid_q;
  // job sequencing; seen_q marks that start has been high a full cycle so a stale done is ignored
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    seen_d = 1'b0;
    valid_d = valid_q;
    dataa_d = dataa_q;
    datab_d = datab_q;
    result_d = result_q;
    tag_d = tag_q;
    tcnt_d = tcnt_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty && !valid_q) begin
        pop = 1'b1;
        dataa_d = head.a;
        datab_d = head.b;
        tag_d = tcnt_q;
        tcnt_d = tcnt_q + TAG_W'(1);
        result_d = zero_bypass(head);
        state_d = (head.a == '0 || head.b == '0) ? HOLD : ISSUE;
      end
      ISSUE: begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        seen_d = 1'b1;
        if (core_done && seen_q) begin
          result_d = core_result;
          start_d = 1'b0;
          seen_d = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: if (out_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset drops start immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      seen_q <= 1'b0;
      valid_q <= 1'b0;
      dataa_q <= '0;
      datab_q <= '0;
      result_q <= '0;
      tag_q <= '0;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      seen_q <= seen_d;
      valid_q <= valid_d;
      dataa_q <= dataa_d;
      datab_q <= datab_d;
      result_q <= result_d;
      tag_q <= tag_d;
      tcnt_q <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_gcd_job_queue.sv
// tb_gcd_job_queue: randomized and directed checks against a queue-based reference model
module tb_gcd_job_queue;
  localparam int DEPTH = 4;
  localparam int TW = 2;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_ready, core_start, core_done, out_valid, busy;
  logic [31:0] core_dataa, core_datab, core_result, out_result;
  logic [TW-1:0] out_tag;
  int checks = 0, errors = 0;

  gcd_job_queue #(.DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_start(core_start), .core_dataa(core_dataa),
    .core_datab(core_datab), .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // stand-in for gcd_ci: starts on a rising start, pulses done after a random delay
  logic ps, cb;
  int cnt;
  logic [31:0] cres;
  int starts = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps <= 1'b0;
      cb <= 1'b0;
      cnt <= 0;
      cres <= '0;
      core_done <= 1'b0;
      core_result <= '0;
    end else begin
      ps <= core_start;
      core_done <= 1'b0;
      core_result <= $urandom;
      if (core_start && !ps) begin
        cb <= 1'b1;
        cnt <= int'($urandom_range(0, 3));
        cres <= gcd_ref(core_dataa, core_datab);
        starts <= starts + 1;
      end else if (cb) begin
        if (cnt == 0) begin
          core_done <= 1'b1;
          core_result <= cres;
          cb <= 1'b0;
        end else cnt <= cnt - 1;
      end
    end
  end

  // reference model: every accepted job in order, with its expected result and tag
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int t;
  } job_t;
  job_t q[$];
  int exp_tag;
  logic [31:0] got_r[$];
  int got_t[$];
  logic hold;
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      got_r.delete();
      got_t.delete();
      exp_tag = 0;
      hold = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        got_r.push_back(out_result);
        got_t.push_back(int'(out_tag));
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back('{in_a, in_b, gcd_ref(in_a, in_b), exp_tag});
        exp_tag = (exp_tag + 1) % (1 << TW);
      end
      hold = out_valid && !out_ready;
    end
  end

  // per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("busy", busy, q.size() != 0);
      if (q.size() < DEPTH) chk("in_ready_free", in_ready, 1);
      else if (q.size() > DEPTH) chk("in_ready_full", in_ready, 0);
      if (hold) chk("out_valid_held", out_valid, 1);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          chk("out_result", out_result, q[0].r);
          chk("out_tag", out_tag, q[0].t);
        end
      end
      if (core_start) begin
        if (q.size() == 0) chk("spurious_start", core_start, 0);
        else begin
          chk("core_dataa", core_dataa, q[0].a);
          chk("core_datab", core_datab, q[0].b);
          chk("start_nonzero_ops", q[0].a != 0 && q[0].b != 0, 1);
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_got(input int i, input logic [31:0] r, input int t);
    if (i < got_r.size()) begin
      chk($sformatf("result_%0d", i), got_r[i], r);
      chk($sformatf("tag_%0d", i), got_t[i], t);
    end else chk($sformatf("missing_result_%0d", i), got_r.size(), i + 1);
  endtask

  initial begin
    int s0, sent, n, mode;
    logic wacc;
    logic [31:0] ra, rb, g;
    chk("ref_91_21", gcd_ref(91, 21), 7);
    chk("ref_12_18", gcd_ref(12, 18), 6);
    chk("ref_mersenne", gcd_ref(32'd2147483647, 32'd524287), 1);
    chk("ref_0_48", gcd_ref(0, 48), 48);
    chk("ref_36_0", gcd_ref(36, 0), 36);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_dataa", core_dataa, 0);
    chk("rst_core_datab", core_datab, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    s0 = starts;
    push(91, 21);
    wait_valid();
    chk("single_result", out_result, 7);
    chk("single_tag", out_tag, 0);
    wait_idle();
    chk("single_starts", starts - s0, 1);

    do_reset();
    out_ready = 1'b0;
    s0 = starts;
    push(32'd2147483647, 32'd524287);
    push(1, 1);
    push(32'd1000000000, 1);
    push(2, 1023);
    push(3, 3);
    chk("burst_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    wait_idle();
    for (int i = 0; i < 4; i++) chk_got(i, 1, i);
    chk_got(4, 3, 0);
    chk("burst_starts", starts - s0, 5);

    do_reset();
    s0 = starts;
    push(0, 48);
    push(36, 0);
    push(0, 0);
    wait_idle();
    chk_got(0, 48, 0);
    chk_got(1, 36, 1);
    chk_got(2, 0, 2);
    chk("bypass_no_start", starts - s0, 0);

    do_reset();
    out_ready = 1'b0;
    s0 = starts;
    push(12, 18);
    push(35, 14);
    wait_valid();
    repeat (20) @(negedge clk);
    chk("bp_valid", out_valid, 1);
    chk("bp_result", out_result, 6);
    chk("bp_second_not_started", starts - s0, 1);
    out_ready = 1'b1;
    wait_idle();
    chk_got(0, 6, 0);
    chk_got(1, 7, 1);
    chk("bp_starts", starts - s0, 2);

    do_reset();
    repeat (5) push(8, 12);
    wait_idle();
    for (int i = 0; i < 5; i++) chk_got(i, 4, i % 4);

    do_reset();
    push(32'd2147483647, 32'd524287);
    n = 0;
    while (!core_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_wait_start", core_start, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_start", core_start, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(91, 21);
    wait_valid();
    chk("after_rst_result", out_result, 7);
    chk("after_rst_tag", out_tag, 0);
    wait_idle();
    chk("after_rst_count", got_r.size(), 1);

    do_reset();
    sent = 0;
    wacc = 1'b0;
    for (int c = 0; c < 20000 && (sent < 60 || in_valid); c++) begin
      @(negedge clk);
      if (wacc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && sent < 60 && $urandom_range(0, 1) == 1) begin
        mode = int'($urandom_range(0, 3));
        ra = $urandom;
        rb = $urandom;
        if (mode == 0) begin
          if ($urandom_range(0, 1) == 1) ra = 0;
          else rb = 0;
        end else if (mode == 1) begin
          ra = $urandom_range(1, 100);
          rb = $urandom_range(1, 100);
        end else if (mode == 3) begin
          g = $urandom_range(1, 1000);
          ra = g * $urandom_range(1, 1000);
          rb = g * $urandom_range(1, 1000);
        end
        in_a = ra;
        in_b = rb;
        in_valid = 1'b1;
      end
      out_ready = $urandom_range(0, 3) != 0;
      wacc = in_valid && in_ready;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("rand_sent", sent, 60);
    chk("rand_results", got_r.size(), 60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
